// File: rtl/bram_wr_ctrl.sv
// AXI-Stream to BRAM frame writer: stores DEPTH beats per frame and flags bad tlast placement.
// Optional BRAM_WR_TSTRB_EN: derive per-lane write enables from s00_axis_tstrb.
module bram_wr_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                       m00_axis_aclk,
    input  logic                       m00_axis_aresetn,
    input  logic                       rx_enable,
    input  logic                       s00_axis_tvalid,
    output logic                       s00_axis_tready,
    input  logic [9*DATA_WIDTH-1:0]    s00_axis_tdata,
    input  logic [9*DATA_WIDTH/8-1:0]  s00_axis_tstrb,
    input  logic                       s00_axis_tlast,
    output logic [ADDRESS_WIDTH-1:0]   write_addr,
    output logic                       write_en,
    output logic [8:0]                 write_lane_en,
    output logic [9*DATA_WIDTH-1:0]    write_data,
    output logic                       frame_done,
    output logic                       frame_err,
    output logic                       busy
);
    localparam int LANE_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

    state_t                   state, next_state;
    logic [ADDRESS_WIDTH-1:0] cnt;
    logic                     at_end;
    logic                     handshake;
    logic                     wr;
    logic [8:0]               lane_sel;

    assign at_end = (cnt == LAST_IDX);
    assign busy   = (state != IDLE);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        next_state      = state;
        s00_axis_tready = 1'b0;
        unique case (state)
            IDLE:        s00_axis_tready = rx_enable;
            RECV, FLUSH: s00_axis_tready = 1'b1;
            default:     s00_axis_tready = 1'b0;
        endcase
        // tready is forced low while reset is held so nothing is accepted before the block is live.
        s00_axis_tready = s00_axis_tready & m00_axis_aresetn;
        handshake       = s00_axis_tvalid & s00_axis_tready;
        wr              = handshake & (state != FLUSH);
        if (wr) begin
            if (s00_axis_tlast)  next_state = IDLE;
            else if (at_end)     next_state = FLUSH;
            else                 next_state = RECV;
        end else if (handshake && s00_axis_tlast) begin
            next_state = IDLE;
        end
    end

`ifdef BRAM_WR_TSTRB_EN
    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < 9; i++) begin
            lane_sel[i] = &s00_axis_tstrb[i*LANE_BYTES +: LANE_BYTES];
        end
    end
`else
    logic unused_tstrb;
    assign unused_tstrb = ^s00_axis_tstrb;
    assign lane_sel     = '1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Write port is registered: everything lands one cycle after the handshake.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            cnt           <= '0;
            write_en      <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
            write_lane_en <= '0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            write_en      <= wr;
            write_lane_en <= wr ? lane_sel : 9'h000;
            frame_done    <= wr & s00_axis_tlast & at_end;
            frame_err     <= wr & (s00_axis_tlast ^ at_end);
            if (wr) begin
                write_addr <= cnt;
                write_data <= s00_axis_tdata;
                cnt        <= (s00_axis_tlast || at_end) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bram_wr_ctrl.sv
// Scoreboard bench for bram_wr_ctrl: driver pushes expected writes, negedge monitor pops and compares.
// Honours BRAM_WR_TSTRB_EN the same way the design does.
module tb_bram_wr_ctrl;
    localparam int DW = 16, DEPTH = 2500, AW = 12, BW = 9 * DW, SW = 9 * DW / 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          rx_enable = 1'b1, tvalid = 1'b0, tlast = 1'b0;
    logic          tready;
    logic [BW-1:0] tdata = '0;
    logic [SW-1:0] tstrb = '1;
    logic [AW-1:0] write_addr;
    logic          write_en, frame_done, frame_err, busy;
    logic [8:0]    write_lane_en;
    logic [BW-1:0] write_data;

    bram_wr_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .rx_enable(rx_enable),
        .s00_axis_tvalid(tvalid), .s00_axis_tready(tready), .s00_axis_tdata(tdata),
        .s00_axis_tstrb(tstrb), .s00_axis_tlast(tlast), .write_addr(write_addr),
        .write_en(write_en), .write_lane_en(write_lane_en), .write_data(write_data),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic [8:0]    lanes;
        logic          done;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0, checks = 0;
    int            done_cnt = 0, err_cnt = 0;
    int            pos = 0;
    logic          flushing = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [BW-1:0] last_data = '0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [8:0] lanes_of(input logic [SW-1:0] s);
        logic [8:0] l;
        l = 9'h1FF;
`ifdef BRAM_WR_TSTRB_EN
        for (int i = 0; i < 9; i++) l[i] = s[2*i] & s[2*i+1];
`endif
        return l;
    endfunction

    function automatic logic in_frame();
        return (pos != 0) || flushing;
    endfunction

    // Reference: a frame is DEPTH beats; tlast must coincide with beat DEPTH-1, beats past it are dropped.
    task automatic model_beat(input logic [BW-1:0] d, input logic [SW-1:0] s, input logic l);
        exp_t e;
        if (flushing) begin
            if (l) flushing = 1'b0;
            return;
        end
        e.addr  = AW'(pos);
        e.data  = d;
        e.lanes = lanes_of(s);
        e.done  = l && (pos == DEPTH - 1);
        e.err   = (l && pos < DEPTH - 1) || (!l && pos == DEPTH - 1);
        exp_q.push_back(e);
        if (pos == DEPTH - 1 && !l) flushing = 1'b1;
        pos = (l || pos == DEPTH - 1) ? 0 : pos + 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (write_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d written, none expected", write_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 160'(write_addr), 160'(e.addr));
                    check("write_data", 160'(write_data), 160'(e.data));
                    check("write_lane_en", 160'(write_lane_en), 160'(e.lanes));
                    check("pulses", 160'({frame_done, frame_err}), 160'({e.done, e.err}));
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else begin
                check("idle_lanes_pulses", 160'({write_lane_en, frame_done, frame_err}), 160'(0));
                check("addr_hold", 160'(write_addr), 160'(last_addr));
                check("data_hold", 160'(write_data), 160'(last_data));
            end
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
        end
    end

    // Entered and left at a negedge; tready is checked against the reference before each edge.
    task automatic send_beat(input logic [BW-1:0] d, input logic [SW-1:0] s, input logic l, input int gap);
        tvalid = 1'b0;
        repeat (gap) @(negedge clk);
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        tvalid = 1'b1;
        for (int w = 0; w <= 20; w++) begin
            #1;
            check("tready", 160'(tready), 160'(in_frame() || rx_enable));
            if (tready) begin
                @(posedge clk);
                model_beat(d, s, l);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check("handshake_timeout", 160'(0), 160'(1));
        tvalid = 1'b0;
    endtask

    // mode 0: back-to-back, index data; 1: tvalid toggling; 2: random gaps/data/strobes/rx_enable.
    task automatic run_frame(input int nbeats, input int last_idx, input int mode, input logic [SW-1:0] strb5);
        logic [159:0] r;
        logic [BW-1:0] d;
        logic [SW-1:0] s;
        logic [15:0]   idx;
        int            gap;
        for (int i = 0; i < nbeats; i++) begin
            idx = 16'(i);
            d   = {9{idx}};
            s   = (i == 5) ? strb5 : '1;
            gap = (mode == 1 && i > 0) ? 1 : 0;
            rx_enable = 1'b1;
            if (mode == 2) begin
                r   = {$urandom, $urandom, $urandom, $urandom, $urandom};
                d   = r[BW-1:0];
                s   = ($urandom_range(0, 1) == 0) ? SW'($urandom) : '1;
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                if (in_frame()) rx_enable = 1'($urandom_range(0, 1));
            end
            send_beat(d, s, i == last_idx, gap);
            check("busy", 160'(busy), 160'(in_frame()));
        end
        tvalid    = 1'b0;
        tlast     = 1'b0;
        rx_enable = 1'b1;
        repeat (2) @(negedge clk);
        check("queue_drained", 160'(exp_q.size()), 160'(0));
    endtask

    task automatic check_all_zero();
        check("rst_tready", 160'(tready), 160'(0));
        check("rst_write_en", 160'(write_en), 160'(0));
        check("rst_write_addr", 160'(write_addr), 160'(0));
        check("rst_write_data", 160'(write_data), 160'(0));
        check("rst_lane_en", 160'(write_lane_en), 160'(0));
        check("rst_pulses", 160'({frame_done, frame_err}), 160'(0));
        check("rst_busy", 160'(busy), 160'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, kind, n;
        repeat (2) @(negedge clk);
        check_all_zero();
        @(negedge clk);
        rst_n = 1'b1;

        // rx_enable low in IDLE: nothing accepted
        rx_enable = 1'b0;
        tvalid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("idle_no_ready", 160'(tready), 160'(0));
            @(negedge clk);
        end
        tvalid    = 1'b0;
        rx_enable = 1'b1;

        d0 = done_cnt; e0 = err_cnt;
        run_frame(DEPTH, DEPTH - 1, 0, '1);
        check("full_done", 160'(done_cnt - d0), 160'(1));
        check("full_err", 160'(err_cnt - e0), 160'(0));

        d0 = done_cnt; e0 = err_cnt;
        run_frame(DEPTH, DEPTH - 1, 1, '1);
        check("toggle_done", 160'(done_cnt - d0), 160'(1));
        check("toggle_err", 160'(err_cnt - e0), 160'(0));

        d0 = done_cnt; e0 = err_cnt;
        run_frame(100, 99, 0, '1);
        run_frame(5, 4, 0, '1);
        check("short_err", 160'(err_cnt - e0), 160'(2));
        check("short_done", 160'(done_cnt - d0), 160'(0));

        d0 = done_cnt; e0 = err_cnt;
        run_frame(DEPTH + 10, DEPTH + 9, 0, '1);
        check("long_err", 160'(err_cnt - e0), 160'(1));
        check("long_done", 160'(done_cnt - d0), 160'(0));

        // reset mid-frame right after beat 999 has been written
        d0 = done_cnt; e0 = err_cnt;
        run_frame(1000, -1, 0, '1);
        #2 rst_n = 1'b0;
        #1 check_all_zero();
        pos = 0; flushing = 1'b0; last_addr = '0; last_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_no_pulse", 160'({done_cnt - d0, err_cnt - e0}), 160'(0));
        run_frame(DEPTH, DEPTH - 1, 2, '1);
        check("after_reset_done", 160'(done_cnt - d0), 160'(1));

        // lane strobes on beat 5
        run_frame(DEPTH, DEPTH - 1, 0, 18'h3FFFC);

        for (int f = 0; f < 3; f++) begin
            kind = $urandom_range(0, 2);
            n    = (kind == 0) ? DEPTH : (kind == 1) ? $urandom_range(1, DEPTH - 1) : DEPTH + $urandom_range(1, 20);
            run_frame(n, n - 1, 2, '1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
